pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 5, pipeline stage count (0=IF, 1=ID, 2=EX, 3=MEM, NSTAGE-1=WB); legal range 4..8.
REQ-002 SHALL have parameter RAW, default 4, register-address width.
REQ-003 SHALL have parameter BR_STAGE, default 2, stage where branches resolve; legal values 1 or 2.
REQ-004 SHALL have parameter MEM_STAGE, default 3, data-memory stage; legal range BR_STAGE+1..NSTAGE-2.
REQ-005 SHALL have parameter CW, default 16, width of the retire counter.
REQ-006 SHALL have clk, input, 1, clock.
REQ-007 SHALL have rst_n, input, 1; reset is rst_n, asynchronous, active-low; clock is clk.
REQ-008 SHALL have id_rs and id_rt, input, RAW each, source registers of the instruction in ID.
REQ-009 SHALL have id_use_rs and id_use_rt, input, 1 each, source-valid qualifiers.
REQ-010 SHALL have id_halt, input, 1, instruction in ID is HLT.
REQ-011 SHALL have ex_rd, input, RAW, and ex_memread, input, 1, destination register and load flag of the instruction in EX.
REQ-012 SHALL have br_taken, input, 1, taken branch in BR_STAGE.
REQ-013 SHALL have imem_busy and dmem_busy, input, 1 each, memory wait requests.
REQ-014 SHALL have pc_write, output, 1, PC update enable, and pc_sel_br, output, 1, select branch target.
REQ-015 SHALL have hold and flush, output, NSTAGE-1 each; bit k applies to the register feeding stage k+1.
REQ-016 SHALL have valid, output, NSTAGE-1; bit k means stage k+1 holds a real instruction.
REQ-017 SHALL have hlt, output, 1, registered halt flag, and retired, output, CW, count of retired instructions.

Function
REQ-018 SHALL apply these conditions in priority order: dmem wait, branch, load-use, halt-fetch, imem wait.
REQ-019 SHALL define dmem wait as dmem_busy & valid[MEM_STAGE-1]: hold registers 0..MEM_STAGE-1, flush register MEM_STAGE, pc_write=0, and ignore br_taken.
REQ-020 SHALL define branch as br_taken & valid[BR_STAGE-1] without dmem wait: flush registers 0..BR_STAGE-1, pc_write=1, pc_sel_br=1, same cycle.
REQ-021 SHALL define load-use as ex_memread & valid[1] & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)) & valid[0]: hold register 0, flush register 1, pc_write=0.
REQ-022 SHALL define halt-fetch as id_halt & valid[0], or state DRAIN/HALTED: pc_write=0, flush register 0.
REQ-023 SHALL handle imem wait (imem_busy) by setting pc_write=0 and flushing register 0.
REQ-024 SHALL otherwise set pc_write=1, pc_sel_br=0, and hold=flush=0.
REQ-025 SHALL never assert hold[k] and flush[k] together.
REQ-026 SHALL update valid[k] each cycle as: hold -> keep; flush -> 0; else valid[k-1] (k=0 loads 1).
REQ-027 SHALL track an internal halt tag per register k>=1, moving like valid and loading id_halt & valid[0] at k=1.
REQ-028 SHALL implement FSM RUN->DRAIN when the halt tag enters register BR_STAGE-1 (no longer squashable).
REQ-029 SHALL implement FSM DRAIN->HALTED when the halt tag enters register NSTAGE-2.
REQ-030 SHALL keep the FSM in HALTED until reset.
REQ-031 SHALL assert hlt the cycle after entering HALTED and hold it high.
REQ-032 SHALL let a halt squashed by a branch in RUN leave the FSM in RUN, with fetch resuming the next cycle.
REQ-033 SHALL increment retired when valid[NSTAGE-2] & ~hold[NSTAGE-2], wrapping 2^CW-1 -> 0.
REQ-034 SHALL increment retired for the halt instruction itself.

Reset
REQ-035 SHALL on rst_n low, asynchronously set valid=0, halt tags=0, state=RUN, hlt=0, retired=0.
REQ-036 SHALL while rst_n is low drive pc_write=0, pc_sel_br=0, hold=0, flush=all ones.
REQ-037 SHALL on reset mid-stall or mid-drain discard all pending state, with no residual hold.

Structure
REQ-038 SHALL define the FSM state enum (RUN, DRAIN, HALTED) and parameter defaults in shared package pipe_pkg.
REQ-039 SHALL implement the load-use comparator as sub-module pipe_hazard_det (combinational).
REQ-040 SHALL keep all other logic in pipe_ctrl.

Verification
REQ-041 SHALL cover: ex_memread=1, ex_rd=3, id_rs=3, id_use_rs=1, all valid -> one cycle hold[0]=1, flush[1]=1, pc_write=0, then normal flow.
REQ-042 SHALL cover: br_taken=1 with BR_STAGE=2 -> same cycle flush[1:0]=2'b11, pc_sel_br=1; valid[1:0]=0 next cycle.
REQ-043 SHALL cover: dmem_busy high 3 cycles with br_taken=1 -> hold[2:0]=3'b111, flush[3]=1, pc_write=0 for 3 cycles; branch taken on cycle 4.
REQ-044 SHALL cover: id_halt in a clean pipe, NSTAGE=5 -> pc_write low from that cycle; hlt=1 four cycles later; retired increments by 1 for HLT.
REQ-045 SHALL cover: id_halt with br_taken the same cycle -> state stays RUN, hlt stays 0, pc_write=1 next cycle.
REQ-046 SHALL cover: retired preloaded to 16'hFFFF via 65535 retirements, one more retirement -> 16'h0000; rst_n pulsed mid-DRAIN -> hlt=0, valid=0 immediately.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding and
// default geometry used by the interface and the controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam int NSTAGE_DEF    = 5;
    localparam int RAW_DEF       = 4;
    localparam int BR_STAGE_DEF  = 2;
    localparam int MEM_STAGE_DEF = 3;
    localparam int CW_DEF        = 16;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the datapath (master) and the pipeline controller (slave).
interface pipe_ctrl_if #(
    parameter int NSTAGE = pipe_pkg::NSTAGE_DEF,
    parameter int RAW    = pipe_pkg::RAW_DEF,
    parameter int CW     = pipe_pkg::CW_DEF
);
    logic [RAW-1:0]    id_rs;
    logic [RAW-1:0]    id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_halt;
    logic [RAW-1:0]    ex_rd;
    logic              ex_memread;
    logic              br_taken;
    logic              imem_busy;
    logic              dmem_busy;
    logic              pc_write;
    logic              pc_sel_br;
    logic [NSTAGE-2:0] hold;
    logic [NSTAGE-2:0] flush;
    logic [NSTAGE-2:0] valid;
    logic              hlt;
    logic [CW-1:0]     retired;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_halt, ex_rd, ex_memread,
               br_taken, imem_busy, dmem_busy,
        input  pc_write, pc_sel_br, hold, flush, valid, hlt, retired
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_halt, ex_rd, ex_memread,
               br_taken, imem_busy, dmem_busy,
        output pc_write, pc_sel_br, hold, flush, valid, hlt, retired
    );
endinterface

// File: rtl/pipe_hazard_det.sv
// Load-use comparator: a load in EX whose destination feeds a source of the
// instruction in ID. Register 0 is hard-wired and never creates a dependency.
module pipe_hazard_det #(
    parameter int RAW = pipe_pkg::RAW_DEF
) (
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic           id_use_rs,
    input  logic           id_use_rt,
    input  logic           id_valid,
    input  logic [RAW-1:0] ex_rd,
    input  logic           ex_memread,
    input  logic           ex_valid,
    output logic           hazard
);
    // Dependency check between the EX load and the ID sources
    always_comb begin
        hazard = ex_memread & ex_valid & id_valid & (ex_rd != {RAW{1'b0}}) &
                 ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
    end
endmodule

// File: rtl/pipe_ctrl.sv
// In-order pipeline controller: stall/flush arbitration, per-stage valid
// tracking, halt drain FSM and retired-instruction counter.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int NSTAGE    = NSTAGE_DEF,
    parameter int RAW       = RAW_DEF,
    parameter int BR_STAGE  = BR_STAGE_DEF,
    parameter int MEM_STAGE = MEM_STAGE_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    pipe_ctrl_if.slave bus
);
    localparam int NR = NSTAGE - 1;
    // With BR_STAGE=1 the halt is past the branch point once it leaves ID
    localparam int DRAIN_IDX = (BR_STAGE > 1) ? BR_STAGE - 1 : 1;

    logic [NR-1:0] valid_r, valid_in_s, valid_nxt_s;
    logic [NR-1:0] hold_s, flush_s;
    logic [NR-2:1] tag_r;
    logic [NR-1:1] tag_in_s, tag_nxt_s;
    state_e        state_r;
    logic          hlt_r;
    logic [CW-1:0] retired_r;
    logic          hazard_s, dmem_wait_s, branch_s, halt_fetch_s;
    logic          pc_write_s, pc_sel_br_s;

    pipe_hazard_det #(.RAW(RAW)) u_hazard (
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .id_use_rs  (bus.id_use_rs),
        .id_use_rt  (bus.id_use_rt),
        .id_valid   (valid_r[0]),
        .ex_rd      (bus.ex_rd),
        .ex_memread (bus.ex_memread),
        .ex_valid   (valid_r[1]),
        .hazard     (hazard_s)
    );

    assign dmem_wait_s  = bus.dmem_busy & valid_r[MEM_STAGE-1];
    assign branch_s     = bus.br_taken & valid_r[BR_STAGE-1] & ~dmem_wait_s;
    assign halt_fetch_s = (bus.id_halt & valid_r[0]) | (state_r != RUN);

    // Priority arbitration of hold/flush/PC controls
    always_comb begin
        hold_s      = {NR{1'b0}};
        flush_s     = {NR{1'b0}};
        pc_write_s  = 1'b1;
        pc_sel_br_s = 1'b0;
        if (!rst_n) begin
            flush_s    = {NR{1'b1}};
            pc_write_s = 1'b0;
        end else if (dmem_wait_s) begin
            for (int k = 0; k < MEM_STAGE; k++) begin
                hold_s[k] = 1'b1;
            end
            flush_s[MEM_STAGE] = 1'b1;
            pc_write_s         = 1'b0;
        end else if (branch_s) begin
            for (int k = 0; k < BR_STAGE; k++) begin
                flush_s[k] = 1'b1;
            end
            pc_sel_br_s = 1'b1;
        end else if (hazard_s) begin
            hold_s[0]  = 1'b1;
            flush_s[1] = 1'b1;
            pc_write_s = 1'b0;
        end else if (halt_fetch_s || bus.imem_busy) begin
            flush_s[0] = 1'b1;
            pc_write_s = 1'b0;
        end else begin
            pc_write_s = 1'b1;
        end
    end

    // Next valid bits and halt tags; both advance like pipeline registers
    always_comb begin
        valid_in_s = {valid_r[NR-2:0], 1'b1};
        tag_in_s   = {tag_r[NR-2:1], bus.id_halt & valid_r[0]};
        valid_nxt_s = {NR{1'b0}};
        tag_nxt_s   = {(NR-1){1'b0}};
        for (int k = 0; k < NR; k++) begin
            if (hold_s[k]) begin
                valid_nxt_s[k] = valid_r[k];
            end else if (flush_s[k]) begin
                valid_nxt_s[k] = 1'b0;
            end else begin
                valid_nxt_s[k] = valid_in_s[k];
            end
        end
        for (int k = 1; k < NR - 1; k++) begin
            if (hold_s[k]) begin
                tag_nxt_s[k] = tag_r[k];
            end else if (flush_s[k]) begin
                tag_nxt_s[k] = 1'b0;
            end else begin
                tag_nxt_s[k] = tag_in_s[k];
            end
        end
        // The last register is never held, so its tag is not stored
        tag_nxt_s[NR-1] = flush_s[NR-1] ? 1'b0 : tag_in_s[NR-1];
    end

    // Pipeline occupancy and halt tag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {NR{1'b0}};
            tag_r   <= {(NR-2){1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
            tag_r   <= tag_nxt_s[NR-2:1];
        end
    end

    // Halt FSM with registered hlt flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
            hlt_r   <= 1'b0;
        end else begin
            case (state_r)
                RUN:     if (tag_nxt_s[DRAIN_IDX]) state_r <= DRAIN;
                DRAIN:   if (tag_nxt_s[NR-1]) state_r <= HALTED;
                HALTED:  hlt_r <= 1'b1;
                default: state_r <= RUN;
            endcase
        end
    end

    // Retired counter, wraps naturally at 2^CW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_r <= {CW{1'b0}};
        end else if (valid_r[NR-1] & ~hold_s[NR-1]) begin
            retired_r <= retired_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign bus.pc_write  = pc_write_s;
    assign bus.pc_sel_br = pc_sel_br_s;
    assign bus.hold      = hold_s;
    assign bus.flush     = flush_s;
    assign bus.valid     = valid_r;
    assign bus.hlt       = hlt_r;
    assign bus.retired   = retired_r;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// against a stage-occupancy reference model.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    localparam int NS = 5;
    localparam int RW = 4;
    localparam int CWW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.NSTAGE(NS), .RAW(RW), .CW(CWW)) bus ();

    pipe_ctrl #(.NSTAGE(NS), .RAW(RW), .BR_STAGE(2), .MEM_STAGE(3), .CW(CWW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_run = 0;
    int n_fail = 0;

    // Reference model: which stages (1=ID .. 4=WB) hold a real instruction / a HLT
    bit          m_v[5];
    bit          m_h[5];
    int          m_phase;          // 0 running, 1 draining, 2 halted
    bit          m_hlt;
    logic [15:0] m_ret;
    bit          st[5];            // stage keeps its content this cycle
    bit          bb[5];            // stage receives a bubble this cycle
    logic [3:0]  e_hold, e_flush;
    logic        e_pcw, e_sel;

    task automatic model_reset();
        for (int s = 0; s < 5; s++) begin m_v[s] = 1'b0; m_h[s] = 1'b0; end
        m_phase = 0; m_hlt = 1'b0; m_ret = 16'd0;
    endtask

    task automatic model_eval();
        bit dw, br, lu, ff;
        for (int s = 0; s < 5; s++) begin st[s] = 1'b0; bb[s] = 1'b0; end
        e_pcw = 1'b1; e_sel = 1'b0;
        if (!rst_n) begin
            for (int s = 1; s < 5; s++) bb[s] = 1'b1;
            e_pcw = 1'b0;
        end else begin
            dw = bus.dmem_busy && m_v[3];
            br = !dw && bus.br_taken && m_v[2];
            lu = !dw && !br && bus.ex_memread && m_v[2] && m_v[1] && (bus.ex_rd != 4'd0) &&
                 ((bus.id_use_rs && bus.id_rs == bus.ex_rd) || (bus.id_use_rt && bus.id_rt == bus.ex_rd));
            ff = !dw && !br && !lu && ((bus.id_halt && m_v[1]) || m_phase != 0 || bus.imem_busy);
            if (dw) begin st[1] = 1'b1; st[2] = 1'b1; st[3] = 1'b1; bb[4] = 1'b1; e_pcw = 1'b0; end
            else if (br) begin bb[1] = 1'b1; bb[2] = 1'b1; e_sel = 1'b1; end
            else if (lu) begin st[1] = 1'b1; bb[2] = 1'b1; e_pcw = 1'b0; end
            else if (ff) begin bb[1] = 1'b1; e_pcw = 1'b0; end
        end
        for (int s = 1; s < 5; s++) begin e_hold[s-1] = st[s]; e_flush[s-1] = bb[s]; end
    endtask

    task automatic model_advance();
        bit nv[5], nh[5];
        bit id_is_halt;
        id_is_halt = bus.id_halt && m_v[1];
        nv[0] = 1'b0; nh[0] = 1'b0;
        for (int s = 1; s < 5; s++) begin
            if (st[s])      begin nv[s] = m_v[s]; nh[s] = m_h[s]; end
            else if (bb[s]) begin nv[s] = 1'b0;   nh[s] = 1'b0;   end
            else if (s == 1) begin nv[s] = 1'b1;  nh[s] = 1'b0;   end
            else begin nv[s] = m_v[s-1]; nh[s] = (s == 2) ? id_is_halt : m_h[s-1]; end
        end
        if (m_v[4] && !st[4]) m_ret = m_ret + 16'd1;
        if (m_phase == 2) m_hlt = 1'b1;
        if (m_phase == 0 && nh[2]) m_phase = 1;
        else if (m_phase == 1 && nh[4]) m_phase = 2;
        for (int s = 0; s < 5; s++) begin m_v[s] = nv[s]; m_h[s] = nh[s]; end
    endtask

    function automatic logic [3:0] m_valid();
        return {m_v[4], m_v[3], m_v[2], m_v[1]};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_advance();
        #1;
    endtask

    task automatic set_idle();
        bus.id_rs = 4'd0; bus.id_rt = 4'd0; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
        bus.id_halt = 1'b0; bus.ex_rd = 4'd0; bus.ex_memread = 1'b0; bus.br_taken = 1'b0;
        bus.imem_busy = 1'b0; bus.dmem_busy = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin set_idle(); model_eval(); tick(); end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; #2; tick(); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_idle(); model_reset(); #3;
        n_run++; if (bus.valid !== 4'h0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0000", bus.valid); end
        n_run++; if (bus.hlt !== 1'b0) begin n_fail++; $display("FAIL rst_hlt got=%b exp=0", bus.hlt); end
        n_run++; if (bus.retired !== 16'h0000) begin n_fail++; $display("FAIL rst_retired got=%h exp=0000", bus.retired); end
        n_run++; if ({bus.pc_write, bus.pc_sel_br} !== 2'b00) begin n_fail++; $display("FAIL rst_pc got=%b exp=00", {bus.pc_write, bus.pc_sel_br}); end
        n_run++; if (bus.hold !== 4'h0) begin n_fail++; $display("FAIL rst_hold got=%b exp=0000", bus.hold); end
        n_run++; if (bus.flush !== 4'hF) begin n_fail++; $display("FAIL rst_flush got=%b exp=1111", bus.flush); end
        tick(); rst_n = 1'b1;
        idle(4);
        n_run++; if (bus.valid !== 4'hF) begin n_fail++; $display("FAIL fill_valid got=%b exp=1111", bus.valid); end
    endtask

    task automatic test_load_use();
        set_idle(); bus.ex_memread = 1'b1; bus.ex_rd = 4'd3; bus.id_rs = 4'd3; bus.id_use_rs = 1'b1;
        model_eval(); @(negedge clk);
        n_run++; if (bus.hold !== 4'b0001) begin n_fail++; $display("FAIL lu_hold got=%b exp=0001", bus.hold); end
        n_run++; if (bus.flush !== 4'b0010) begin n_fail++; $display("FAIL lu_flush got=%b exp=0010", bus.flush); end
        n_run++; if (bus.pc_write !== 1'b0) begin n_fail++; $display("FAIL lu_pcw got=%b exp=0", bus.pc_write); end
        tick();
        set_idle(); model_eval(); @(negedge clk);
        n_run++; if ({bus.hold, bus.flush, bus.pc_write} !== 9'b0000_0000_1) begin n_fail++; $display("FAIL lu_after got=%b exp=000000001", {bus.hold, bus.flush, bus.pc_write}); end
        n_run++; if (bus.valid !== 4'b1101) begin n_fail++; $display("FAIL lu_valid got=%b exp=1101", bus.valid); end
        tick();
    endtask

    task automatic test_branch();
        idle(4);
        set_idle(); bus.br_taken = 1'b1; model_eval(); @(negedge clk);
        n_run++; if (bus.flush !== 4'b0011) begin n_fail++; $display("FAIL br_flush got=%b exp=0011", bus.flush); end
        n_run++; if ({bus.hold, bus.pc_write, bus.pc_sel_br} !== 6'b0000_11) begin n_fail++; $display("FAIL br_ctl got=%b exp=000011", {bus.hold, bus.pc_write, bus.pc_sel_br}); end
        tick();
        set_idle(); model_eval(); @(negedge clk);
        n_run++; if (bus.valid[1:0] !== 2'b00) begin n_fail++; $display("FAIL br_valid got=%b exp=00", bus.valid[1:0]); end
        tick();
    endtask

    task automatic test_dmem_wait();
        idle(4);
        for (int i = 0; i < 3; i++) begin
            set_idle(); bus.dmem_busy = 1'b1; bus.br_taken = 1'b1; model_eval(); @(negedge clk);
            n_run++; if ({bus.hold, bus.flush} !== 8'b0111_1000) begin n_fail++; $display("FAIL dw_hf cyc=%0d got=%b exp=01111000", i, {bus.hold, bus.flush}); end
            n_run++; if ({bus.pc_write, bus.pc_sel_br} !== 2'b00) begin n_fail++; $display("FAIL dw_pc cyc=%0d got=%b exp=00", i, {bus.pc_write, bus.pc_sel_br}); end
            tick();
        end
        set_idle(); bus.br_taken = 1'b1; model_eval(); @(negedge clk);
        n_run++; if ({bus.flush, bus.pc_write, bus.pc_sel_br} !== 6'b0011_11) begin n_fail++; $display("FAIL dw_br got=%b exp=001111", {bus.flush, bus.pc_write, bus.pc_sel_br}); end
        tick();
    endtask

    task automatic test_halt();
        logic [15:0] r0;
        idle(4);
        set_idle(); bus.id_halt = 1'b1; model_eval(); r0 = m_ret; @(negedge clk);
        n_run++; if ({bus.pc_write, bus.flush} !== 5'b0_0001) begin n_fail++; $display("FAIL hlt_fetch got=%b exp=00001", {bus.pc_write, bus.flush}); end
        tick();
        for (int i = 1; i < 4; i++) begin
            set_idle(); model_eval(); @(negedge clk);
            n_run++; if ({bus.pc_write, bus.hlt} !== 2'b00) begin n_fail++; $display("FAIL hlt_drain cyc=%0d got=%b exp=00", i, {bus.pc_write, bus.hlt}); end
            tick();
        end
        set_idle(); model_eval(); @(negedge clk);
        n_run++; if (bus.hlt !== 1'b1) begin n_fail++; $display("FAIL hlt_set got=%b exp=1", bus.hlt); end
        n_run++; if (bus.retired !== r0 + 16'd4) begin n_fail++; $display("FAIL hlt_ret got=%h exp=%h", bus.retired, r0 + 16'd4); end
        tick(); idle(2);
        n_run++; if ({bus.hlt, bus.pc_write, bus.retired} !== {2'b10, r0 + 16'd4}) begin n_fail++; $display("FAIL hlt_stay got=%h exp=%h", {bus.hlt, bus.pc_write, bus.retired}, {2'b10, r0 + 16'd4}); end
        do_reset();
    endtask

    task automatic test_halt_squash();
        idle(4);
        set_idle(); bus.id_halt = 1'b1; bus.br_taken = 1'b1; model_eval(); @(negedge clk);
        n_run++; if ({bus.pc_write, bus.pc_sel_br} !== 2'b11) begin n_fail++; $display("FAIL sq_pc got=%b exp=11", {bus.pc_write, bus.pc_sel_br}); end
        tick();
        set_idle(); model_eval(); @(negedge clk);
        n_run++; if ({bus.pc_write, bus.flush} !== 5'b1_0000) begin n_fail++; $display("FAIL sq_next got=%b exp=10000", {bus.pc_write, bus.flush}); end
        tick(); idle(5);
        set_idle(); model_eval(); @(negedge clk);
        n_run++; if ({bus.hlt, bus.pc_write} !== 2'b01) begin n_fail++; $display("FAIL sq_run got=%b exp=01", {bus.hlt, bus.pc_write}); end
        tick();
    endtask

    task automatic test_random(int n);
        for (int i = 0; i < n; i++) begin
            bus.id_rs = 4'($urandom_range(0, 3)); bus.id_rt = 4'($urandom_range(0, 3));
            bus.ex_rd = 4'($urandom_range(0, 3));
            bus.id_use_rs = 1'($urandom_range(0, 1)); bus.id_use_rt = 1'($urandom_range(0, 1));
            bus.ex_memread = ($urandom_range(0, 2) == 0); bus.id_halt = ($urandom_range(0, 29) == 0);
            bus.br_taken = ($urandom_range(0, 5) == 0); bus.imem_busy = ($urandom_range(0, 4) == 0);
            bus.dmem_busy = ($urandom_range(0, 4) == 0);
            model_eval(); @(negedge clk);
            n_run++;
            if ({bus.hold, bus.flush, bus.pc_write, bus.pc_sel_br} !== {e_hold, e_flush, e_pcw, e_sel}) begin
                n_fail++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", i, {bus.hold, bus.flush, bus.pc_write, bus.pc_sel_br}, {e_hold, e_flush, e_pcw, e_sel});
            end
            n_run++;
            if ({bus.valid, bus.hlt, bus.retired} !== {m_valid(), m_hlt, m_ret}) begin
                n_fail++; $display("FAIL rnd_state cyc=%0d got=%h exp=%h", i, {bus.valid, bus.hlt, bus.retired}, {m_valid(), m_hlt, m_ret});
            end
            if ($urandom_range(0, 199) == 0 || (m_hlt && $urandom_range(0, 3) == 0)) begin
                rst_n = 1'b0; #1;
                n_run++;
                if ({bus.valid, bus.hlt, bus.pc_write, bus.hold, bus.flush} !== 14'b0000_0_0_0000_1111) begin
                    n_fail++; $display("FAIL rnd_rst cyc=%0d got=%b exp=00000000001111", i, {bus.valid, bus.hlt, bus.pc_write, bus.hold, bus.flush});
                end
                tick(); rst_n = 1'b1;
            end else begin
                tick();
            end
        end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        for (int i = 0; i < 70000 && m_ret != 16'hFFFF; i++) begin
            set_idle(); model_eval(); tick();
        end
        n_run++; if (bus.retired !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max got=%h exp=ffff", bus.retired); end
        idle(1);
        n_run++; if (bus.retired !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got=%h exp=0000", bus.retired); end
        set_idle(); bus.id_halt = 1'b1; model_eval(); tick();
        idle(1);
        rst_n = 1'b0; #1;
        n_run++; if ({bus.hlt, bus.valid} !== 5'b0_0000) begin n_fail++; $display("FAIL drain_rst got=%b exp=00000", {bus.hlt, bus.valid}); end
        n_run++; if ({bus.pc_write, bus.hold, bus.flush} !== 9'b0_0000_1111) begin n_fail++; $display("FAIL drain_rst_ctl got=%b exp=000001111", {bus.pc_write, bus.hold, bus.flush}); end
        tick(); rst_n = 1'b1;
        set_idle(); model_eval(); @(negedge clk);
        n_run++; if ({bus.pc_write, bus.hold, bus.flush} !== 9'b1_0000_0000) begin n_fail++; $display("FAIL post_rst got=%b exp=100000000", {bus.pc_write, bus.hold, bus.flush}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_dmem_wait();
        test_halt();
        test_halt_squash();
        test_random(1500);
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
